// File: rtl/axilite_noc_req_sched_pkg.sv
// Shared definitions for the AXI-Lite to NoC request scheduler.
// The scheduler states, the message lengths and types, the fixed source and
// destination coordinates, and the flit builders all live here.
package axilite_noc_req_sched_pkg;

  localparam int unsigned C_M_AXI_LITE_ADDR_WIDTH = 32;
  localparam int unsigned C_M_AXI_LITE_DATA_WIDTH = 32;
  localparam int unsigned NOC_DATA_WIDTH          = 64;
  localparam int unsigned MSG_MSHRID_WIDTH        = 8;
  localparam int unsigned MSG_ADDR_WIDTH          = 48;
  localparam int unsigned MSG_OPTIONS_2_WIDTH     = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR0 = 3'd1,
    HDR1 = 3'd2,
    HDR2 = 3'd3,
    DATA = 3'd4
  } sched_state_t;

  localparam logic [7:0] MSG_TYPE_LOAD_MEM  = 8'd19;
  localparam logic [7:0] MSG_TYPE_STORE_MEM = 8'd20;
  localparam logic [7:0] MSG_LEN_STORE      = 8'd3;
  localparam logic [7:0] MSG_LEN_LOAD       = 8'd2;

  localparam logic [3:0] NOC_FBITS_MEM = 4'b0010;
  localparam logic [3:0] NOC_FBITS_L1  = 4'b0000;

  localparam logic [13:0] DST_CHIPID = 14'd0;
  localparam logic [7:0]  DST_X      = 8'd1;
  localparam logic [7:0]  DST_Y      = 8'd2;
  localparam logic [13:0] SRC_CHIPID = 14'd0;
  localparam logic [7:0]  SRC_X      = 8'd3;
  localparam logic [7:0]  SRC_Y      = 8'd4;

  // HDR0: dst chipid/x/y/fbits, msg_length, msg_type, mshrid, options_1 = 0
  function automatic logic [NOC_DATA_WIDTH-1:0] mk_hdr0(
    input logic [7:0]                  len,
    input logic [7:0]                  mtype,
    input logic [MSG_MSHRID_WIDTH-1:0] mshrid
  );
    return {DST_CHIPID, DST_X, DST_Y, NOC_FBITS_MEM, len, mtype, mshrid, 6'd0};
  endfunction

  // HDR1: address in the upper field, options_2 in the low 16 bits
  function automatic logic [NOC_DATA_WIDTH-1:0] mk_hdr1(
    input logic [C_M_AXI_LITE_ADDR_WIDTH-1:0]   addr,
    input logic [C_M_AXI_LITE_DATA_WIDTH/8-1:0] opt2
  );
    return {MSG_ADDR_WIDTH'(addr), MSG_OPTIONS_2_WIDTH'(opt2)};
  endfunction

  // HDR2: src chipid/x/y/fbits, remainder zero
  function automatic logic [NOC_DATA_WIDTH-1:0] mk_hdr2();
    return {SRC_CHIPID, SRC_X, SRC_Y, NOC_FBITS_L1, 30'd0};
  endfunction

endpackage

// File: rtl/axilite_noc_req_sched_arb.sv
// Two-way write/read arbiter for the request scheduler.
// Macro AXILITE_NOC_SCHED_RR_EN: defined -> round-robin with a last-grant
// register (reset value: read); undefined -> fixed priority, write over read.
module axilite_noc_req_arb (
`ifdef AXILITE_NOC_SCHED_RR_EN
  input  logic clk,
  input  logic rst,
  input  logic take,
`endif
  input  logic req_wr,
  input  logic req_rd,
  output logic gnt_wr,
  output logic gnt_rd
);

`ifdef AXILITE_NOC_SCHED_RR_EN
  logic last_rd_q;

  // Remember which type was granted most recently
  always_ff @(posedge clk) begin
    if (rst)       last_rd_q <= 1'b1;
    else if (take) last_rd_q <= gnt_rd;
  end

  // On contention grant the type opposite to the last grant
  always_comb begin
    gnt_wr = req_wr & (~req_rd | last_rd_q);
    gnt_rd = req_rd & (~req_wr | ~last_rd_q);
  end
`else
  // Write always wins over read
  always_comb begin
    gnt_wr = req_wr;
    gnt_rd = req_rd & ~req_wr;
  end
`endif

endmodule

// File: rtl/axilite_noc_req_sched.sv
// AXI-Lite request capture and NoC packet scheduler.
// Holds AW/W/AR independently, arbitrates one pending request at a time and
// emits it as a 3-flit load or 4-flit store, tracking outstanding responses.
// Macro AXILITE_NOC_SCHED_RR_EN selects round-robin arbitration.
module axilite_noc_req_sched
  import axilite_noc_req_sched_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [C_M_AXI_LITE_ADDR_WIDTH-1:0]   m_axi_awaddr,
  input  logic                                 m_axi_awvalid,
  output logic                                 m_axi_awready,
  input  logic [C_M_AXI_LITE_DATA_WIDTH-1:0]   m_axi_wdata,
  input  logic [C_M_AXI_LITE_DATA_WIDTH/8-1:0] m_axi_wstrb,
  input  logic                                 m_axi_wvalid,
  output logic                                 m_axi_wready,
  input  logic [C_M_AXI_LITE_ADDR_WIDTH-1:0]   m_axi_araddr,
  input  logic                                 m_axi_arvalid,
  output logic                                 m_axi_arready,
  output logic                                 sched_splitter_val,
  output logic [NOC_DATA_WIDTH-1:0]            sched_splitter_data,
  input  logic                                 splitter_sched_rdy,
  input  logic                                 resp_done,
  output logic [3:0]                           outstanding,
  output logic                                 sched_busy
);

  sched_state_t                          state_q, state_d;
  logic                                  aw_full, w_full, ar_full;
  logic [C_M_AXI_LITE_ADDR_WIDTH-1:0]    aw_addr_q, ar_addr_q;
  logic [C_M_AXI_LITE_DATA_WIDTH-1:0]    w_data_q;
  logic [C_M_AXI_LITE_DATA_WIDTH/8-1:0]  w_strb_q;
  logic                                  is_wr_q;
  logic [3:0]                            outstanding_q;
  logic [MSG_MSHRID_WIDTH-1:0]           mshrid_q;
  logic                                  gnt_wr, gnt_rd, take, fire, last_flit, dec;

  assign m_axi_awready = ~aw_full;
  assign m_axi_wready  = ~w_full;
  assign m_axi_arready = ~ar_full;
  assign outstanding   = outstanding_q;
  assign sched_busy    = (state_q != IDLE);

  axilite_noc_req_arb u_arb (
`ifdef AXILITE_NOC_SCHED_RR_EN
    .clk    (clk),
    .rst    (rst),
    .take   (take),
`endif
    .req_wr (aw_full & w_full),
    .req_rd (ar_full),
    .gnt_wr (gnt_wr),
    .gnt_rd (gnt_rd)
  );

  assign take      = (state_q == IDLE) && (outstanding_q < 4'(MAX_OUTSTANDING)) && (gnt_wr || gnt_rd);
  assign fire      = sched_splitter_val & splitter_sched_rdy;
  assign last_flit = fire & ((state_q == DATA) | ((state_q == HDR2) & ~is_wr_q));
  assign dec       = resp_done & (outstanding_q != 4'd0);

  // AW/W holding registers: fill on handshake, drain when the store completes
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (last_flit && is_wr_q) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
    end else begin
      if (m_axi_awvalid && !aw_full) begin
        aw_full   <= 1'b1;
        aw_addr_q <= m_axi_awaddr;
      end
      if (m_axi_wvalid && !w_full) begin
        w_full   <= 1'b1;
        w_data_q <= m_axi_wdata;
        w_strb_q <= m_axi_wstrb;
      end
    end
  end

  // AR holding register: fill on handshake, drain when the load completes
  always_ff @(posedge clk) begin
    if (rst) begin
      ar_full   <= 1'b0;
      ar_addr_q <= '0;
    end else if (last_flit && !is_wr_q) begin
      ar_full <= 1'b0;
    end else if (m_axi_arvalid && !ar_full) begin
      ar_full   <= 1'b1;
      ar_addr_q <= m_axi_araddr;
    end
  end

  // State, granted type, outstanding count and mshrid bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      is_wr_q       <= 1'b0;
      outstanding_q <= '0;
      mshrid_q      <= '0;
    end else begin
      state_q <= state_d;
      if (take) is_wr_q <= gnt_wr;
      if (last_flit && !dec)      outstanding_q <= outstanding_q + 4'd1;
      else if (!last_flit && dec) outstanding_q <= outstanding_q - 4'd1;
      if (last_flit) mshrid_q <= mshrid_q + 1'b1;
    end
  end

  // Next state and flit contents; data is zero whenever val is low
  always_comb begin
    state_d             = state_q;
    sched_splitter_val  = 1'b0;
    sched_splitter_data = '0;
    case (state_q)
      IDLE: if (take) state_d = HDR0;
      HDR0: begin
        sched_splitter_val  = 1'b1;
        sched_splitter_data = is_wr_q ? mk_hdr0(MSG_LEN_STORE, MSG_TYPE_STORE_MEM, mshrid_q)
                                      : mk_hdr0(MSG_LEN_LOAD,  MSG_TYPE_LOAD_MEM,  mshrid_q);
        if (splitter_sched_rdy) state_d = HDR1;
      end
      HDR1: begin
        sched_splitter_val  = 1'b1;
        sched_splitter_data = is_wr_q ? mk_hdr1(aw_addr_q, w_strb_q) : mk_hdr1(ar_addr_q, '0);
        if (splitter_sched_rdy) state_d = HDR2;
      end
      HDR2: begin
        sched_splitter_val  = 1'b1;
        sched_splitter_data = mk_hdr2();
        if (splitter_sched_rdy) state_d = is_wr_q ? DATA : IDLE;
      end
      DATA: begin
        sched_splitter_val  = 1'b1;
        sched_splitter_data = NOC_DATA_WIDTH'(w_data_q);
        if (splitter_sched_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axilite_noc_req_sched.sv
// Directed self-checking bench for axilite_noc_req_sched (MAX_OUTSTANDING=2).
// Build with or without AXILITE_NOC_SCHED_RR_EN; arbitration expectations follow it.
module tb_axilite_noc_req_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] m_axi_awaddr = '0;
  logic        m_axi_awvalid = 1'b0;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata = '0;
  logic [3:0]  m_axi_wstrb = '0;
  logic        m_axi_wvalid = 1'b0;
  logic        m_axi_wready;
  logic [31:0] m_axi_araddr = '0;
  logic        m_axi_arvalid = 1'b0;
  logic        m_axi_arready;
  logic        sched_splitter_val;
  logic [63:0] sched_splitter_data;
  logic        splitter_sched_rdy = 1'b1;
  logic        resp_done = 1'b0;
  logic [3:0]  outstanding;
  logic        sched_busy;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc = 0;
  int unsigned exp_mshr = 0;
  logic [63:0] flits[$];
  int unsigned fcyc[$];

  localparam logic [63:0] HDR0_ST_BASE = 64'h0000_0408_80C5_0000;
  localparam logic [63:0] HDR0_LD_BASE = 64'h0000_0408_8084_C000;
  localparam logic [63:0] HDR2_EXP     = 64'h0000_0C10_0000_0000;

  axilite_noc_req_sched #(.MAX_OUTSTANDING(2)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .m_axi_awaddr        (m_axi_awaddr),
    .m_axi_awvalid       (m_axi_awvalid),
    .m_axi_awready       (m_axi_awready),
    .m_axi_wdata         (m_axi_wdata),
    .m_axi_wstrb         (m_axi_wstrb),
    .m_axi_wvalid        (m_axi_wvalid),
    .m_axi_wready        (m_axi_wready),
    .m_axi_araddr        (m_axi_araddr),
    .m_axi_arvalid       (m_axi_arvalid),
    .m_axi_arready       (m_axi_arready),
    .sched_splitter_val  (sched_splitter_val),
    .sched_splitter_data (sched_splitter_data),
    .splitter_sched_rdy  (splitter_sched_rdy),
    .resp_done           (resp_done),
    .outstanding         (outstanding),
    .sched_busy          (sched_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted flit and the cycle it was accepted in
  always @(negedge clk) begin
    if (!rst && sched_splitter_val && splitter_sched_rdy) begin
      flits.push_back(sched_splitter_data);
      fcyc.push_back(cyc);
    end
  end

  function automatic logic [63:0] hdr0_st(input int unsigned m);
    return HDR0_ST_BASE | (64'(m % 256) << 6);
  endfunction

  function automatic logic [63:0] hdr0_ld(input int unsigned m);
    return HDR0_LD_BASE | (64'(m % 256) << 6);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_flits();
    flits.delete();
    fcyc.delete();
  endtask

  task automatic put_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int unsigned n = 0;
    m_axi_awaddr = a; m_axi_wdata = d; m_axi_wstrb = s;
    m_axi_awvalid = 1'b1; m_axi_wvalid = 1'b1;
    while (!(m_axi_awready && m_axi_wready) && n < 100) begin tick(); n++; end
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL put_write: awready/wready stayed low, got %b/%b want 1/1", m_axi_awready, m_axi_wready);
    end
    tick();
    m_axi_awvalid = 1'b0; m_axi_wvalid = 1'b0;
  endtask

  task automatic put_read(input logic [31:0] a);
    int unsigned n = 0;
    m_axi_araddr = a; m_axi_arvalid = 1'b1;
    while (!m_axi_arready && n < 100) begin tick(); n++; end
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL put_read: arready stayed low, got %b want 1", m_axi_arready);
    end
    tick();
    m_axi_arvalid = 1'b0;
  endtask

  task automatic put_both(input logic [31:0] wa, input logic [31:0] d, input logic [3:0] s,
                          input logic [31:0] ra);
    int unsigned n = 0;
    m_axi_awaddr = wa; m_axi_wdata = d; m_axi_wstrb = s; m_axi_araddr = ra;
    m_axi_awvalid = 1'b1; m_axi_wvalid = 1'b1; m_axi_arvalid = 1'b1;
    while (!(m_axi_awready && m_axi_wready && m_axi_arready) && n < 100) begin tick(); n++; end
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL put_both: readies stayed low, got %b%b%b want 111", m_axi_awready, m_axi_wready, m_axi_arready);
    end
    tick();
    m_axi_awvalid = 1'b0; m_axi_wvalid = 1'b0; m_axi_arvalid = 1'b0;
  endtask

  task automatic wait_flits(input int unsigned cnt, input int unsigned budget);
    int unsigned n = 0;
    while (flits.size() < cnt && n < budget) begin tick(); n++; end
    if (flits.size() < cnt) begin
      tests++; fails++;
      $display("FAIL wait_flits: got %0d flits want %0d", flits.size(), cnt);
    end
  endtask

  task automatic pulse_resp();
    resp_done = 1'b1;
    tick();
    resp_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_axi_awvalid = 1'b0; m_axi_wvalid = 1'b0; m_axi_arvalid = 1'b0;
    splitter_sched_rdy = 1'b1; resp_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    exp_mshr = 0;
    clear_flits();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    tests++;
    if (sched_splitter_val !== 1'b0) begin fails++; $display("FAIL reset_val: got %b want 0", sched_splitter_val); end
    tests++;
    if (sched_splitter_data !== 64'd0) begin fails++; $display("FAIL reset_data: got %h want 0", sched_splitter_data); end
    tests++;
    if ({m_axi_awready, m_axi_wready, m_axi_arready} !== 3'b111) begin
      fails++; $display("FAIL reset_ready: got %b%b%b want 111", m_axi_awready, m_axi_wready, m_axi_arready);
    end
    tests++;
    if (sched_busy !== 1'b0 || outstanding !== 4'd0) begin
      fails++; $display("FAIL reset_busy_out: got busy=%b out=%0d want busy=0 out=0", sched_busy, outstanding);
    end
    rst = 1'b0;
    exp_mshr = 0;
    clear_flits();
  endtask

  task automatic test_write();
    logic [63:0] exp [4];
    exp[0] = hdr0_st(exp_mshr);
    exp[1] = 64'h0000_0000_0040_000F;
    exp[2] = HDR2_EXP;
    exp[3] = 64'h0000_0000_DEAD_BEEF;
    clear_flits();
    put_write(32'h40, 32'hDEAD_BEEF, 4'hF);
    wait_flits(4, 20);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (flits.size() <= i || flits[i] !== exp[i]) begin
        fails++; $display("FAIL write_flit%0d: got %h want %h", i, (flits.size() > i) ? flits[i] : 64'hx, exp[i]);
      end
    end
    tests++;
    if (fcyc.size() < 4 || fcyc[3] - fcyc[0] != 3) begin
      fails++; $display("FAIL write_consecutive: got span %0d want 3", (fcyc.size() >= 4) ? fcyc[3] - fcyc[0] : 0);
    end
    tests++;
    if (outstanding !== 4'd1 || sched_busy !== 1'b0) begin
      fails++; $display("FAIL write_outstanding: got out=%0d busy=%b want out=1 busy=0", outstanding, sched_busy);
    end
    exp_mshr++;
    pulse_resp();
    tests++;
    if (outstanding !== 4'd0) begin fails++; $display("FAIL write_resp: got out=%0d want 0", outstanding); end
  endtask

  task automatic test_backpressure();
    logic [63:0] h1;
    h1 = 64'h0000_0000_0080_0000;
    clear_flits();
    put_read(32'h80);
    wait_flits(1, 20);
    splitter_sched_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) splitter_sched_rdy = 1'b1;
      @(negedge clk);
      tests++;
      if (sched_splitter_val !== 1'b1 || sched_splitter_data !== h1) begin
        fails++; $display("FAIL bp_hdr1_hold%0d: got val=%b data=%h want val=1 data=%h", i, sched_splitter_val, sched_splitter_data, h1);
      end
      tick();
    end
    wait_flits(3, 20);
    repeat (4) tick();
    tests++;
    if (flits.size() != 3) begin fails++; $display("FAIL bp_flit_count: got %0d want 3", flits.size()); end
    tests++;
    if (flits[0] !== hdr0_ld(exp_mshr) || flits[0][29:22] !== 8'd2) begin
      fails++; $display("FAIL bp_hdr0: got %h want %h", flits[0], hdr0_ld(exp_mshr));
    end
    tests++;
    if (flits[1] !== h1 || flits[2] !== HDR2_EXP) begin
      fails++; $display("FAIL bp_hdr12: got %h %h want %h %h", flits[1], flits[2], h1, HDR2_EXP);
    end
    exp_mshr++;
    pulse_resp();
  endtask

  task automatic test_arbitration();
    clear_flits();
    put_both(32'h100, 32'h1111_2222, 4'h3, 32'h200);
    wait_flits(7, 40);
    tests++;
    if (flits[0] !== hdr0_st(exp_mshr) || flits[1] !== 64'h0000_0000_0100_0003 || flits[3] !== 64'h0000_0000_1111_2222) begin
      fails++; $display("FAIL arb_first_write: got %h %h %h", flits[0], flits[1], flits[3]);
    end
    tests++;
    if (flits[4] !== hdr0_ld(exp_mshr + 1) || flits[5] !== 64'h0000_0000_0200_0000) begin
      fails++; $display("FAIL arb_then_read: got %h %h want %h %h", flits[4], flits[5], hdr0_ld(exp_mshr + 1), 64'h0000_0000_0200_0000);
    end
    exp_mshr += 2;
    pulse_resp(); pulse_resp();
    clear_flits();
    put_write(32'h140, 32'h5555_6666, 4'hF);
    wait_flits(4, 20);
    exp_mshr++;
    pulse_resp();
    clear_flits();
    put_both(32'h180, 32'h3333_4444, 4'hC, 32'h280);
    wait_flits(7, 40);
    tests++;
`ifdef AXILITE_NOC_SCHED_RR_EN
    if (flits[0] !== hdr0_ld(exp_mshr) || flits[3] !== hdr0_st(exp_mshr + 1)) begin
      fails++; $display("FAIL arb_rr_after_write: got %h %h want %h %h", flits[0], flits[3], hdr0_ld(exp_mshr), hdr0_st(exp_mshr + 1));
    end
`else
    if (flits[0] !== hdr0_st(exp_mshr) || flits[4] !== hdr0_ld(exp_mshr + 1)) begin
      fails++; $display("FAIL arb_fixed_after_write: got %h %h want %h %h", flits[0], flits[4], hdr0_st(exp_mshr), hdr0_ld(exp_mshr + 1));
    end
`endif
    exp_mshr += 2;
    pulse_resp(); pulse_resp();
  endtask

  task automatic test_max_outstanding();
    int unsigned k;
    clear_flits();
    put_read(32'h1000);
    put_read(32'h1004);
    put_read(32'h1008);
    wait_flits(6, 60);
    repeat (6) tick();
    tests++;
    if (flits.size() != 6 || outstanding !== 4'd2 || m_axi_arready !== 1'b0 || sched_busy !== 1'b0) begin
      fails++; $display("FAIL max_out_hold: got flits=%0d out=%0d arready=%b busy=%b want 6 2 0 0", flits.size(), outstanding, m_axi_arready, sched_busy);
    end
    k = cyc;
    pulse_resp();
    wait_flits(9, 20);
    tests++;
    if (fcyc.size() < 7 || fcyc[6] != k + 2) begin
      fails++; $display("FAIL max_out_release: got hdr0 cycle %0d want %0d", (fcyc.size() >= 7) ? fcyc[6] : 0, k + 2);
    end
    tests++;
    if (flits[6] !== hdr0_ld(exp_mshr + 2) || flits[7] !== 64'h0000_0000_1008_0000) begin
      fails++; $display("FAIL max_out_third: got %h %h", flits[6], flits[7]);
    end
    exp_mshr += 3;
    pulse_resp(); pulse_resp();
    tests++;
    if (outstanding !== 4'd0) begin fails++; $display("FAIL max_out_drain: got %0d want 0", outstanding); end
  endtask

  task automatic test_resp_edge();
    pulse_resp();
    tests++;
    if (outstanding !== 4'd0) begin fails++; $display("FAIL resp_at_zero: got %0d want 0", outstanding); end
    clear_flits();
    put_read(32'h2000);
    wait_flits(3, 20);
    clear_flits();
    put_read(32'h2004);
    wait_flits(2, 20);
    resp_done = 1'b1;
    tick();
    resp_done = 1'b0;
    tests++;
    if (flits.size() != 3 || outstanding !== 4'd1) begin
      fails++; $display("FAIL resp_coincide: got flits=%0d out=%0d want 3 1", flits.size(), outstanding);
    end
    exp_mshr += 2;
    pulse_resp();
  endtask

  task automatic test_reset_mid();
    clear_flits();
    put_write(32'h500, 32'h0BAD_F00D, 4'h1);
    wait_flits(4, 20);
    clear_flits();
    put_read(32'h600);
    wait_flits(2, 20);
    tests++;
    if (sched_busy !== 1'b1 || outstanding !== 4'd1 || m_axi_arready !== 1'b0) begin
      fails++; $display("FAIL rstmid_pre: got busy=%b out=%0d arready=%b want 1 1 0", sched_busy, outstanding, m_axi_arready);
    end
    rst = 1'b1;
    tick();
    tests++;
    if (sched_splitter_val !== 1'b0 || outstanding !== 4'd0 || sched_busy !== 1'b0) begin
      fails++; $display("FAIL rstmid_state: got val=%b out=%0d busy=%b want 0 0 0", sched_splitter_val, outstanding, sched_busy);
    end
    tests++;
    if ({m_axi_awready, m_axi_wready, m_axi_arready} !== 3'b111) begin
      fails++; $display("FAIL rstmid_ready: got %b%b%b want 111", m_axi_awready, m_axi_wready, m_axi_arready);
    end
    rst = 1'b0;
    exp_mshr = 0;
    repeat (4) tick();
    tests++;
    if (flits.size() != 2 || outstanding !== 4'd0) begin
      fails++; $display("FAIL rstmid_abandon: got flits=%0d out=%0d want 2 0", flits.size(), outstanding);
    end
  endtask

  task automatic test_mshrid_wrap();
    logic [63:0] f;
    for (int i = 0; i < 258; i++) begin
      clear_flits();
      put_read(32'h4000 + 32'(i) * 4);
      wait_flits(3, 20);
      f = flits[0];
      tests++;
      if (f !== hdr0_ld(exp_mshr)) begin
        fails++; $display("FAIL mshrid_pkt%0d: got mshrid %0d want %0d", i, f[13:6], exp_mshr % 256);
      end
      exp_mshr++;
      pulse_resp();
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_backpressure();
    test_arbitration();
    test_max_outstanding();
    test_resp_edge();
    test_reset_mid();
    test_mshrid_wrap();
    do_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/axilite_noc_req_sched.md
AXILITE_NOC_REQ_SCHED -- requirements
Module: axilite_noc_req_sched

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of issued NoC requests without a response (1..15).
REQ-002 SHALL have ports: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: m_axi_awaddr  in  C_M_AXI_LITE_ADDR_WIDTH; m_axi_awvalid  in  1; m_axi_awready  out  1.
REQ-004 SHALL have ports: m_axi_wdata  in  C_M_AXI_LITE_DATA_WIDTH; m_axi_wstrb  in  C_M_AXI_LITE_DATA_WIDTH/8; m_axi_wvalid  in  1; m_axi_wready  out  1.
REQ-005 SHALL have ports: m_axi_araddr  in  C_M_AXI_LITE_ADDR_WIDTH; m_axi_arvalid  in  1; m_axi_arready  out  1.
REQ-006 SHALL have ports: sched_splitter_val  out  1; sched_splitter_data  out  NOC_DATA_WIDTH; splitter_sched_rdy  in  1 (NoC flit output).
REQ-007 SHALL have ports: resp_done  in  1  one-cycle pulse per completed response; outstanding  out  4  issued-not-completed count; sched_busy  out  1  high when not in IDLE.

Function
REQ-008 SHALL capture AW, W and AR into independent holding registers; each ready is high exactly when its holding register is empty.
REQ-009 SHALL treat a write as pending when both AW and W are held, and a read as pending when AR is held.
REQ-010 SHALL have states IDLE, HDR0, HDR1, HDR2, DATA; grant occurs only in IDLE, only when a request is pending and outstanding < MAX_OUTSTANDING.
REQ-011 SHALL enter HDR0 in the cycle after the grant; sched_splitter_val SHALL be high in HDR0..DATA and low in IDLE.
REQ-012 SHALL advance state only on sched_splitter_val & splitter_sched_rdy; sched_splitter_data SHALL stay stable while val is high and rdy is low.
REQ-013 SHALL sequence a store as HDR0->HDR1->HDR2->DATA->IDLE (msg_length 3, MSG_TYPE_STORE_MEM) and a load as HDR0->HDR1->HDR2->IDLE (msg_length 2, MSG_TYPE_LOAD_MEM).
REQ-014 SHALL build HDR0 from fixed dst chipid/x/y, dst fbits NOC_FBITS_MEM, msg_length, msg_type and mshrid; HDR1 from the held address, with the held wstrb in MSG_OPTIONS_2 for stores and 0 for loads; HDR2 from fixed src chipid/x/y and src fbits NOC_FBITS_L1; DATA as wdata zero-extended.
REQ-015 SHALL, on acceptance of the last flit, clear the granted channel's holding registers, increment outstanding, increment the mshrid counter (wrapping modulo 2^MSG_MSHRID_WIDTH) and return to IDLE.
REQ-016 SHALL keep accepting into the non-granted channel's empty holding registers during emission.
REQ-017 SHALL leave outstanding unchanged when an increment and resp_done coincide, and SHALL ignore resp_done when outstanding is 0.
REQ-018 SHALL hold the grant in IDLE when outstanding == MAX_OUTSTANDING, keeping the requests held, and grant in the cycle after outstanding drops below it.

Reset
REQ-019 SHALL, on rst, set the state to IDLE, clear all holding registers, and set outstanding=0, mshrid=0, last-grant=read and sched_splitter_val=0.
REQ-020 SHALL, on rst mid-packet, abandon the packet without completing it or incrementing outstanding.
REQ-021 SHALL, on rst, drive sched_splitter_data=0, awready=wready=arready=1 and sched_busy=0.

Configuration
REQ-022 SHALL, with AXILITE_NOC_SCHED_RR_EN defined, arbitrate round-robin: when both are pending, grant the type opposite to the last grant.
REQ-023 SHALL, without AXILITE_NOC_SCHED_RR_EN, use fixed priority with write over read; the last-grant register SHALL then be absent.

Structure
REQ-024 SHALL place state encodings, the store and load length constants, and the fixed src/dst coordinates in the shared define header.
REQ-025 SHALL implement arbitration in one sub-module, axilite_noc_req_arb (2-way, RR or fixed selected per the configuration macro).

Verification
REQ-026 SHALL cover: write awaddr=0x40, wdata=0xDEADBEEF, wstrb=0xF with rdy=1 -> 4 consecutive flits, HDR1 addr 0x40, DATA 0xDEADBEEF, outstanding=1.
REQ-027 SHALL cover: read araddr=0x80 with rdy low for 3 cycles during HDR1 -> HDR1 held stable 4 cycles, 3 flits total, msg_length=2.
REQ-028 SHALL cover: AW and AR pending together in the same cycle, RR enabled, last grant=read -> write packet first, then read; fixed mode -> write first.
REQ-029 SHALL cover: MAX_OUTSTANDING=2, three reads -> third read held until resp_done, HDR0 appears 2 cycles after the pulse.
REQ-030 SHALL cover: rst asserted during HDR2 -> val low the next cycle, outstanding=0, all readies high.
REQ-031 SHALL cover: issuing 2^MSG_MSHRID_WIDTH+1 packets -> mshrid wraps to 0 and then reaches 1.
